// File: rtl/dht11_driver.sv
// rtl/dht11_driver.sv - single-wire DHT11 read master: start pulse, response/bit decode, checksum
module dht11_driver #(
  parameter int CYCLES_PER_US = 50,
  parameter int START_LOW_US  = 18000,
  parameter int TIMEOUT_US    = 255,
  parameter int BIT_THRESH_US = 50
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Enable_dht11,
  input  logic       Dht_in,
  output logic       Dht_oe,
  output logic       Wait_dht11,
  output logic [7:0] Umi_int,
  output logic [7:0] Umi_float,
  output logic [7:0] Temp_int,
  output logic [7:0] Temp_float,
  output logic [7:0] CRC,
  output logic       Error
);

  localparam int PW = (CYCLES_PER_US > 1) ? $clog2(CYCLES_PER_US) : 1;
  localparam logic [PW-1:0] PRESC_MAX  = PW'(CYCLES_PER_US - 1);
  localparam logic [14:0]   START_M1   = 15'(START_LOW_US - 1);
  localparam logic [14:0]   TIMEOUT_M1 = 15'(TIMEOUT_US - 1);
  localparam logic [14:0]   THRESH     = 15'(BIT_THRESH_US);

  typedef enum logic [3:0] {
    S_IDLE,
    S_START_LOW,
    S_REL,
    S_RESP_LOW,
    S_RESP_HIGH,
    S_BIT_LOW,
    S_BIT_HIGH,
    S_CHECK,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          prev_q, prev_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [14:0]   us_q, us_d;
  logic [5:0]    bit_cnt_q, bit_cnt_d;
  logic [39:0]   shift_q, shift_d;
  logic [7:0]    umi_int_q, umi_int_d;
  logic [7:0]    umi_float_q, umi_float_d;
  logic [7:0]    temp_int_q, temp_int_d;
  logic [7:0]    temp_float_q, temp_float_d;
  logic [7:0]    crc_q, crc_d;
  logic          err_q, err_d;
  logic          oe_q, oe_d;

  logic          rise, fall, tick, at_start, at_timeout, waiting, abort;
  logic [7:0]    sum;

  always_comb begin
    sync1_d      = Dht_in;
    sync2_d      = sync1_q;
    prev_d       = sync2_q;
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    umi_int_d    = umi_int_q;
    umi_float_d  = umi_float_q;
    temp_int_d   = temp_int_q;
    temp_float_d = temp_float_q;
    crc_d        = crc_q;
    err_d        = err_q;

    rise       = sync2_q & ~prev_q;
    fall       = ~sync2_q & prev_q;
    tick       = (presc_q == PRESC_MAX);
    // "count = N" fires on the tick that moves the counter onto N
    at_start   = tick && (us_q == START_M1);
    at_timeout = tick && (us_q == TIMEOUT_M1);
    sum        = shift_q[39:32] + shift_q[31:24] + shift_q[23:16] + shift_q[15:8];
    waiting    = (state_q == S_REL) || (state_q == S_RESP_LOW) || (state_q == S_RESP_HIGH) ||
                 (state_q == S_BIT_LOW) || (state_q == S_BIT_HIGH);
    abort      = !Enable_dht11 && (state_q != S_IDLE) && (state_q != S_DONE);

    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (Enable_dht11) begin
            state_d   = S_START_LOW;
            err_d     = 1'b0;
            bit_cnt_d = 6'd0;
          end
        end
        S_START_LOW: begin
          if (at_start) state_d = S_REL;
        end
        S_REL: begin
          if (fall) state_d = S_RESP_LOW;
        end
        S_RESP_LOW: begin
          if (rise) state_d = S_RESP_HIGH;
        end
        S_RESP_HIGH: begin
          if (fall) state_d = S_BIT_LOW;
        end
        S_BIT_LOW: begin
          if (rise) state_d = S_BIT_HIGH;
        end
        S_BIT_HIGH: begin
          if (fall) begin
            shift_d   = {shift_q[38:0], (us_q >= THRESH)};
            bit_cnt_d = bit_cnt_q + 6'd1;
            state_d   = (bit_cnt_q == 6'd39) ? S_CHECK : S_BIT_LOW;
          end
        end
        S_CHECK: begin
          umi_int_d    = shift_q[39:32];
          umi_float_d  = shift_q[31:24];
          temp_int_d   = shift_q[23:16];
          temp_float_d = shift_q[15:8];
          crc_d        = shift_q[7:0];
          err_d        = (sum != shift_q[7:0]);
          state_d      = S_DONE;
        end
        S_DONE: begin
          if (!Enable_dht11) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase

      // An edge seen in the same cycle as the timeout wins
      if (waiting && at_timeout && (state_d == state_q)) begin
        err_d   = 1'b1;
        state_d = S_DONE;
      end
    end

    oe_d = (state_d == S_START_LOW);

    if (state_d != state_q) begin
      presc_d = '0;
      us_d    = 15'd0;
    end else begin
      presc_d = tick ? '0 : presc_q + PW'(1);
      us_d    = tick ? us_q + 15'd1 : us_q;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q      <= S_IDLE;
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      prev_q       <= 1'b1;
      presc_q      <= '0;
      us_q         <= 15'd0;
      bit_cnt_q    <= 6'd0;
      shift_q      <= 40'd0;
      umi_int_q    <= 8'd0;
      umi_float_q  <= 8'd0;
      temp_int_q   <= 8'd0;
      temp_float_q <= 8'd0;
      crc_q        <= 8'd0;
      err_q        <= 1'b0;
      oe_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      prev_q       <= prev_d;
      presc_q      <= presc_d;
      us_q         <= us_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      umi_int_q    <= umi_int_d;
      umi_float_q  <= umi_float_d;
      temp_int_q   <= temp_int_d;
      temp_float_q <= temp_float_d;
      crc_q        <= crc_d;
      err_q        <= err_d;
      oe_q         <= oe_d;
    end
  end

  assign Dht_oe     = oe_q;
  assign Wait_dht11 = Enable_dht11 && (state_q != S_DONE);
  assign Umi_int    = umi_int_q;
  assign Umi_float  = umi_float_q;
  assign Temp_int   = temp_int_q;
  assign Temp_float = temp_float_q;
  assign CRC        = crc_q;
  assign Error      = err_q;

endmodule

// File: tb/tb_dht11_driver.sv
// tb/tb_dht11_driver.sv - directed + random DHT11 frames against a behavioural sensor and expectation model
`timescale 1ns/1ps
module tb_dht11_driver;

  localparam int CPU   = 2;
  localparam int SLU   = 20;
  localparam int TOU   = 255;
  localparam int US_NS = 10 * CPU;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       Enable_dht11;
  logic       Dht_in;
  logic       Dht_oe;
  logic       Wait_dht11;
  logic [7:0] Umi_int, Umi_float, Temp_int, Temp_float, CRC;
  logic       Error;
  logic       sensor_low;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] exp_b [5];
  logic       exp_err;

  always #5 Clk = ~Clk;

  // Open-drain line with pull-up: either side may pull it low
  assign Dht_in = ~(Dht_oe | sensor_low);

  dht11_driver #(
    .CYCLES_PER_US(CPU),
    .START_LOW_US(SLU),
    .TIMEOUT_US(TOU),
    .BIT_THRESH_US(50)
  ) dut (
    .Clk(Clk),
    .Rst(Rst),
    .Enable_dht11(Enable_dht11),
    .Dht_in(Dht_in),
    .Dht_oe(Dht_oe),
    .Wait_dht11(Wait_dht11),
    .Umi_int(Umi_int),
    .Umi_float(Umi_float),
    .Temp_int(Temp_int),
    .Temp_float(Temp_float),
    .CRC(CRC),
    .Error(Error)
  );

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_umi_int"},    40'(Umi_int),    40'(exp_b[0]));
    chk({tag, "_umi_float"},  40'(Umi_float),  40'(exp_b[1]));
    chk({tag, "_temp_int"},   40'(Temp_int),   40'(exp_b[2]));
    chk({tag, "_temp_float"}, 40'(Temp_float), 40'(exp_b[3]));
    chk({tag, "_crc"},        40'(CRC),        40'(exp_b[4]));
    chk({tag, "_error"},      40'(Error),      40'(exp_err));
  endtask

  task automatic start_read(input string tag, output int oe_cycles);
    int n;
    @(negedge Clk);
    Enable_dht11 = 1'b1;
    exp_err      = 1'b0;
    #1 chk({tag, "_wait_on_enable"}, 40'(Wait_dht11), 40'd1);
    n = 0;
    while (!Dht_oe && n < 10) begin
      @(negedge Clk);
      n++;
    end
    oe_cycles = 0;
    while (Dht_oe && oe_cycles < 1000) begin
      oe_cycles++;
      @(negedge Clk);
    end
  endtask

  task automatic drive_frame(input logic [39:0] f, input int abort_bit);
    #(30 * US_NS);
    sensor_low = 1'b1;
    #(80 * US_NS);
    sensor_low = 1'b0;
    #(80 * US_NS);
    for (int i = 0; i < 40; i++) begin
      sensor_low = 1'b1;
      #(50 * US_NS);
      sensor_low = 1'b0;
      if (i == abort_bit) begin
        #(10 * US_NS);
        Enable_dht11 = 1'b0;
        return;
      end
      #((f[39-i] ? 70 : 27) * US_NS);
    end
    sensor_low = 1'b1;
    #(50 * US_NS);
    sensor_low = 1'b0;
  endtask

  task automatic full_read(input string tag, input logic [7:0] b0, b1, b2, b3, b4);
    int oe_cyc;
    int cyc;
    int sum;
    start_read(tag, oe_cyc);
    chk({tag, "_oe_cycles"}, 40'(oe_cyc), 40'(SLU * CPU));
    drive_frame({b0, b1, b2, b3, b4}, -1);
    cyc = 0;
    while (Wait_dht11 && cyc < 2000) begin
      @(negedge Clk);
      cyc++;
    end
    chk({tag, "_done"}, 40'(Wait_dht11), 40'd0);
    exp_b[0] = b0; exp_b[1] = b1; exp_b[2] = b2; exp_b[3] = b3; exp_b[4] = b4;
    sum      = int'(b0) + int'(b1) + int'(b2) + int'(b3);
    exp_err  = ((sum % 256) != int'(b4));
    check_outputs(tag);
    repeat (5) @(negedge Clk);
    chk({tag, "_wait_held_low"}, 40'(Wait_dht11), 40'd0);
    chk({tag, "_oe_released"},   40'(Dht_oe),     40'd0);
    Enable_dht11 = 1'b0;
    repeat (2) @(negedge Clk);
  endtask

  initial begin
    int         oe_cyc;
    int         cyc;
    logic [7:0] r [5];

    Rst          = 1'b1;
    Enable_dht11 = 1'b0;
    sensor_low   = 1'b0;
    repeat (3) @(negedge Clk);
    Rst = 1'b0;
    for (int i = 0; i < 5; i++) exp_b[i] = 8'h00;
    exp_err = 1'b0;
    @(negedge Clk);
    check_outputs("reset");
    chk("reset_oe",   40'(Dht_oe),     40'd0);
    chk("reset_wait", 40'(Wait_dht11), 40'd0);

    full_read("good",  8'h37, 8'h00, 8'h19, 8'h05, 8'h55);
    full_read("again", 8'h37, 8'h00, 8'h19, 8'h05, 8'h55);
    full_read("badcrc", 8'h37, 8'h00, 8'h19, 8'h05, 8'h54);

    start_read("nosensor", oe_cyc);
    chk("nosensor_oe_cycles", 40'(oe_cyc), 40'(SLU * CPU));
    cyc = 0;
    while (Wait_dht11 && cyc < 2000) begin
      @(negedge Clk);
      cyc++;
    end
    chk("nosensor_timeout_cycles", 40'(cyc), 40'(TOU * CPU));
    exp_err = 1'b1;
    check_outputs("nosensor");
    Enable_dht11 = 1'b0;
    repeat (2) @(negedge Clk);

    full_read("wrap", 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFC);

    for (int i = 0; i < 4; i++) r[i] = 8'($urandom);
    start_read("abort", oe_cyc);
    drive_frame({r[0], r[1], r[2], r[3], 8'h00}, 20);
    @(posedge Clk);
    #1;
    chk("abort_oe",   40'(Dht_oe),     40'd0);
    chk("abort_wait", 40'(Wait_dht11), 40'd0);
    check_outputs("abort");
    repeat (4) @(negedge Clk);

    for (int t = 0; t < 2; t++) begin
      for (int i = 0; i < 4; i++) r[i] = 8'($urandom);
      r[4] = r[0] + r[1] + r[2] + r[3];
      if ($urandom_range(1, 0) == 1) r[4] = r[4] ^ (8'd1 << $urandom_range(7, 0));
      full_read($sformatf("rand%0d", t), r[0], r[1], r[2], r[3], r[4]);
    end

    @(negedge Clk);
    Enable_dht11 = 1'b1;
    cyc = 0;
    while (!Dht_oe && cyc < 10) begin
      @(negedge Clk);
      cyc++;
    end
    repeat (5) @(negedge Clk);
    chk("rst_mid_oe_before", 40'(Dht_oe), 40'd1);
    Rst          = 1'b1;
    Enable_dht11 = 1'b0;
    @(posedge Clk);
    #1;
    for (int i = 0; i < 5; i++) exp_b[i] = 8'h00;
    exp_err = 1'b0;
    chk("rst_mid_oe",   40'(Dht_oe),     40'd0);
    chk("rst_mid_wait", 40'(Wait_dht11), 40'd0);
    check_outputs("rst_mid");
    @(negedge Clk);
    Rst = 1'b0;
    repeat (2) @(negedge Clk);

    full_read("after_rst", 8'h12, 8'h34, 8'h56, 8'h78, 8'h14);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
